// File: rtl/rgb_fade_scheduler.sv
// rgb_fade_scheduler: ramps three PWM levels toward encoder targets, committing all three together on pwm_sync.
module rgb_fade_scheduler #(
    parameter int WIDTH = 8,
    parameter int DIV   = 16,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_sync,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    input  logic [WIDTH-1:0] target2,
    output logic [WIDTH-1:0] level0,
    output logic [WIDTH-1:0] level1,
    output logic [WIDTH-1:0] level2,
    output logic             busy,
    output logic             settled
);
    localparam int PW = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, STEP0, STEP1, STEP2, WAIT_SYNC} state_t;

    state_t           state, state_next;
    logic [PW-1:0]    cnt;
    logic             tick;
    logic [WIDTH-1:0] pend0, pend1, pend2;

    // Distance is taken at WIDTH+1 bits so a large STEP can never wrap past 0 or full scale.
    function automatic logic [WIDTH-1:0] next_level(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] t);
        logic [WIDTH:0] d;
        d = (t > l) ? {1'b0, t} - {1'b0, l} : {1'b0, l} - {1'b0, t};
        return (d <= (WIDTH+1)'(STEP)) ? t : (t > l) ? l + WIDTH'(STEP) : l - WIDTH'(STEP);
    endfunction

    assign tick    = enable && cnt == PW'(DIV - 1);
    assign busy    = state != IDLE;
    assign settled = level0 == target0 && level1 == target1 && level2 == target2;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = (tick && !settled) ? STEP0 : IDLE;
            STEP0:     state_next = STEP1;
            STEP1:     state_next = STEP2;
            STEP2:     state_next = WAIT_SYNC;
            WAIT_SYNC: state_next = pwm_sync ? IDLE : WAIT_SYNC;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            pend0  <= '0;
            pend1  <= '0;
            pend2  <= '0;
            level0 <= '0;
            level1 <= '0;
            level2 <= '0;
        end else begin
            state <= state_next;
            cnt   <= (!enable || tick) ? '0 : cnt + PW'(1);
            if (state == STEP0) pend0 <= next_level(level0, target0);
            if (state == STEP1) pend1 <= next_level(level1, target1);
            if (state == STEP2) pend2 <= next_level(level2, target2);
            if (state == WAIT_SYNC && pwm_sync) begin
                level0 <= pend0;
                level1 <= pend1;
                level2 <= pend2;
            end
        end
    end
endmodule

// File: tb/tb_rgb_fade_scheduler.sv
// tb_rgb_fade_scheduler: scoreboard bench driving a STEP=1/DIV=16 and a STEP=4/DIV=4 instance in parallel.
module tb_rgb_fade_scheduler;
    logic clk = 1'b0;
    logic reset, enable, pwm_sync;
    logic [7:0] t0, t1, t2;
    logic [1:0][2:0][7:0] dl;
    logic [1:0] db, ds;

    typedef struct packed {
        logic [2:0][7:0] l;
        logic            b;
    } exp_t;

    exp_t q0[$], q1[$];
    int stp[2] = '{1, 4};
    int dv[2]  = '{16, 4};
    int mcnt[2], mph[2];
    int ml[2][3], mp[2][3];
    int total = 0, bad = 0;
    bit started = 0;

    always #5 clk = ~clk;

    rgb_fade_scheduler #(.WIDTH(8), .DIV(16), .STEP(1)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .pwm_sync(pwm_sync),
        .target0(t0), .target1(t1), .target2(t2),
        .level0(dl[0][0]), .level1(dl[0][1]), .level2(dl[0][2]),
        .busy(db[0]), .settled(ds[0]));

    rgb_fade_scheduler #(.WIDTH(8), .DIV(4), .STEP(4)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .pwm_sync(pwm_sync),
        .target0(t0), .target1(t1), .target2(t2),
        .level0(dl[1][0]), .level1(dl[1][1]), .level2(dl[1][2]),
        .busy(db[1]), .settled(ds[1]));

    function automatic int nxt(int l, int t, int s);
        if (t == l) return l;
        if (t > l) return (t - l <= s) ? t : l + s;
        return (l - t <= s) ? t : l - s;
    endfunction

    function automatic int tgt(int c);
        return c == 0 ? int'(t0) : c == 1 ? int'(t1) : int'(t2);
    endfunction

    // Reference model: phase 0 idle, 1..3 compute channel phase-1, 4 waits for the period boundary.
    always @(posedge clk) begin
        bit   tk, st;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mcnt[k] = 0;
                mph[k]  = 0;
                for (int c = 0; c < 3; c++) begin ml[k][c] = 0; mp[k][c] = 0; end
            end else begin
                tk = enable && mcnt[k] == dv[k] - 1;
                st = 1;
                for (int c = 0; c < 3; c++) if (ml[k][c] != tgt(c)) st = 0;
                mcnt[k] = enable ? (mcnt[k] + 1) % dv[k] : 0;
                if (mph[k] == 0) begin
                    if (tk && !st) mph[k] = 1;
                end else if (mph[k] <= 3) begin
                    mp[k][mph[k]-1] = nxt(ml[k][mph[k]-1], tgt(mph[k]-1), stp[k]);
                    mph[k]++;
                end else if (pwm_sync) begin
                    for (int c = 0; c < 3; c++) ml[k][c] = mp[k][c];
                    mph[k] = 0;
                end
            end
            for (int c = 0; c < 3; c++) e.l[c] = 8'(ml[k][c]);
            e.b = mph[k] != 0;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        started = 1;
    end

    always @(negedge clk) begin
        exp_t e;
        logic es;
        if (started) for (int k = 0; k < 2; k++) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                total++; bad++;
                $display("FAIL queue inst%0d: got empty, required an entry at %0t", k, $time);
            end else begin
                if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                if (reset) e = '0;
                es = e.l[0] == t0 && e.l[1] == t1 && e.l[2] == t2;
                total++;
                if (dl[k] !== e.l) begin
                    bad++;
                    $display("FAIL levels inst%0d at %0t: got %h required %h", k, $time, dl[k], e.l);
                end
                total++;
                if (db[k] !== e.b) begin
                    bad++;
                    $display("FAIL busy inst%0d at %0t: got %b required %b", k, $time, db[k], e.b);
                end
                total++;
                if (ds[k] !== es) begin
                    bad++;
                    $display("FAIL settled inst%0d at %0t: got %b required %b", k, $time, ds[k], es);
                end
            end
        end
    end

    task automatic wt(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bit hit;
        reset = 1; enable = 1; pwm_sync = 1; t0 = 0; t1 = 0; t2 = 0;
        wt(3); reset = 0;
        wt(100);
        t0 = 5;
        wt(120);
        t0 = 250;
        wt(4200);
        t0 = 255;
        wt(60);
        t0 = 2;
        wt(4200);
        t1 = 10;
        for (int i = 0; i < 3000; i++) begin
            pwm_sync = (i % 256) == 0;
            wt(1);
        end
        pwm_sync = 0; t2 = 200;
        wt(40);
        reset = 1;
        wt(2);
        reset = 0; pwm_sync = 1; t1 = 100;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            wt(1);
            if (mph[0] == 2) begin enable = 0; hit = 1; end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL step1_wait: got no STEP1 within 100 cycles, required one");
        end
        wt(60);
        enable = 1;
        wt(60);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) t0 = 8'($urandom);
            if ($urandom_range(0, 40) == 0) t1 = 8'($urandom);
            if ($urandom_range(0, 40) == 0) t2 = 8'($urandom);
            enable   = $urandom_range(0, 9) != 0;
            pwm_sync = $urandom_range(0, 7) == 0;
            reset    = $urandom_range(0, 700) == 0;
            wt(1);
        end
        reset = 0;
        wt(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
